// File: rtl/ddr_rd_burst_responder_pkg.sv
// Shared constants for the DDR read-burst responder: bus widths, AXI encodings, burst limit.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package ddr_rd_burst_responder_pkg;

    // Default widths for the loader <-> DDR read path.
    localparam int DDR_DATA_WIDTH = 64;
    localparam int DDR_ADDR_SIZE  = 32;
    // Must hold MAX_BURST_LEN and anything above it that the loader may request.
    localparam int DDR_LEN_WIDTH  = 12;

    // AXI4 INCR bursts top out at 256 beats.
    localparam int MAX_BURST_LEN  = 256;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // ARSIZE encoding for a full-width beat: log2 of the number of bytes per beat.
    function automatic logic [2:0] axi_size_for(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/ddr_rd_burst_responder.sv
// Executes one rd_burst request as a single AXI4 INCR read, returns beats, then pulses finish.
// Latency: each accepted R beat appears on rd_burst_data/valid one cycle after its handshake.
// Backpressure: none toward the loader; R is always accepted in DATA, AR held until arready.
//
// Ports:
//   s_clk / s_rst_n         clock, asynchronous active-low reset
//   rd_burst_req/addr/len   loader request, held stable until rd_burst_finish
//   rd_burst_data/valid     returned beats (valid is a one-cycle strobe per beat)
//   rd_burst_finish         one-cycle pulse, coincides with the last forwarded beat
//   m_axi_ar*               AXI4 read-address channel (master)
//   m_axi_r*                AXI4 read-data channel (master)
//   o_err                   sticky error flag: bad length, bad rresp, short or long burst
module ddr_rd_burst_responder
    import ddr_rd_burst_responder_pkg::*;
#(
    parameter int DATA_WIDTH    = DDR_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DDR_ADDR_SIZE,
    parameter int LEN_WIDTH     = DDR_LEN_WIDTH,
    parameter int MAX_BURST_LEN_P = MAX_BURST_LEN
) (
    input  logic                  s_clk,
    input  logic                  s_rst_n,

    input  logic                  rd_burst_req,
    input  logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic [LEN_WIDTH-1:0]  rd_burst_len,
    output logic [DATA_WIDTH-1:0] rd_burst_data,
    output logic                  rd_burst_valid,
    output logic                  rd_burst_finish,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  o_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_LEN_P);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic                   r_hs;

    assign m_axi_arsize  = axi_size_for(DATA_WIDTH);
    assign m_axi_arburst = AXI_BURST_INCR;

    assign r_hs = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state           <= ST_IDLE;
            len_q           <= '0;
            beat_cnt        <= '0;
            m_axi_araddr    <= '0;
            m_axi_arlen     <= '0;
            m_axi_arvalid   <= 1'b0;
            m_axi_rready    <= 1'b0;
            rd_burst_data   <= '0;
            rd_burst_valid  <= 1'b0;
            rd_burst_finish <= 1'b0;
            o_err           <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            rd_burst_valid  <= 1'b0;
            rd_burst_finish <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rd_burst_req) begin
                        len_q    <= rd_burst_len;
                        beat_cnt <= '0;
                        if (rd_burst_len == '0 || rd_burst_len > MAX_LEN) begin
                            // Nothing legal to issue: complete the handshake without touching AXI.
                            state           <= ST_DONE;
                            rd_burst_finish <= 1'b1;
                            if (rd_burst_len > MAX_LEN) begin
                                o_err <= 1'b1;
                            end
                        end else begin
                            state         <= ST_ADDR;
                            m_axi_araddr  <= rd_burst_addr;
                            m_axi_arlen   <= 8'(rd_burst_len - ONE);
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end

                ST_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (r_hs) begin
                        if (beat_cnt < len_q) begin
                            rd_burst_data  <= m_axi_rdata;
                            rd_burst_valid <= 1'b1;
                            beat_cnt       <= beat_cnt + ONE;
                        end else begin
                            // Memory returned more beats than asked for: drain without forwarding.
                            o_err <= 1'b1;
                        end

                        if (m_axi_rresp != AXI_RESP_OKAY) begin
                            o_err <= 1'b1;
                        end

                        if (m_axi_rlast) begin
                            // rlast earlier than beat len-1 means the burst came back short.
                            if (beat_cnt < len_q - ONE) begin
                                o_err <= 1'b1;
                            end
                            m_axi_rready    <= 1'b0;
                            rd_burst_finish <= 1'b1;
                            state           <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Requester still holds req this cycle; it is not re-sampled until IDLE.
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
